// File: rtl/seq_mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation selects and FSM states.
package seq_mul_div_pkg;

   localparam int unsigned MD_OP_BIT = 3;

   typedef enum logic [MD_OP_BIT-1:0] {
      MD_OP_MULT  = 3'd0,
      MD_OP_MULTU = 3'd1,
      MD_OP_DIV   = 3'd2,
      MD_OP_DIVU  = 3'd3,
      MD_OP_MTHI  = 3'd4,
      MD_OP_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      MD_ST_IDLE = 2'd0,
      MD_ST_CALC = 2'd1,
      MD_ST_FIX  = 2'd2
   } md_st_e;

endpackage

// File: rtl/seq_mul_div_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface seq_mul_div_if
   import seq_mul_div_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) ();

   logic [MD_OP_BIT-1:0] op;
   logic                 start;
   logic [WIDTH-1:0]     data_x;
   logic [WIDTH-1:0]     data_y;
   logic                 busy;
   logic                 done;
   logic [WIDTH-1:0]     hi;
   logic [WIDTH-1:0]     lo;

   modport master (
      output op, start, data_x, data_y,
      input  busy, done, hi, lo
   );

   modport slave (
      input  op, start, data_x, data_y,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/seq_mul_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle, sign fix-up in a final cycle.
module seq_mul_div
   import seq_mul_div_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   seq_mul_div_if.slave md
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   md_st_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 is_div_q, is_div_d;
   logic                 res_neg_q, res_neg_d;
   logic                 x_neg_q, x_neg_d;
   logic                 done_q, done_d;

   logic                 is_signed;
   logic [WIDTH-1:0]     x_mag, y_mag;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_trial;
   logic                 div_ge;
   logic [WIDTH-1:0]     div_rem;
   logic [2*WIDTH-1:0]   mul_step, div_step;
   logic [2*WIDTH-1:0]   neg_in, neg_out;
   logic [WIDTH-1:0]     quot_neg;

   always_comb begin
      is_signed = (md.op == MD_OP_MULT) || (md.op == MD_OP_DIV);
      x_mag     = (is_signed && md.data_x[WIDTH-1]) ? -md.data_x : md.data_x;
      y_mag     = (is_signed && md.data_y[WIDTH-1]) ? -md.data_y : md.data_y;

      // acc holds {partial product, remaining multiplier bits}
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_step  = {mul_sum, acc_q[WIDTH-1:1]};

      // acc holds {remainder, dividend bits still to consume / quotient bits produced}
      div_trial = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge    = div_trial >= {1'b0, opnd_q};
      div_rem   = div_trial[WIDTH-1:0] - opnd_q;
      div_step  = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0};

      neg_in    = is_div_q ? {acc_q[2*WIDTH-1:WIDTH], {WIDTH{1'b0}}} : acc_q;
      neg_out   = -neg_in;
      quot_neg  = -acc_q[WIDTH-1:0];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      is_div_d  = is_div_q;
      res_neg_d = res_neg_q;
      x_neg_d   = x_neg_q;
      done_d    = 1'b0;

      unique case (state_q)
         MD_ST_IDLE: begin
            if (md.start) begin
               case (md.op)
                  MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
                     is_div_d  = (md.op == MD_OP_DIV) || (md.op == MD_OP_DIVU);
                     res_neg_d = is_signed && (md.data_x[WIDTH-1] ^ md.data_y[WIDTH-1]);
                     x_neg_d   = is_signed && md.data_x[WIDTH-1];
                     opnd_d    = is_div_d ? y_mag : x_mag;
                     acc_d     = {{WIDTH{1'b0}}, is_div_d ? x_mag : y_mag};
                     cnt_d     = '0;
                     state_d   = MD_ST_CALC;
                  end
                  MD_OP_MTHI: hi_d = md.data_x;
                  MD_OP_MTLO: lo_d = md.data_x;
                  default: ;
               endcase
            end
         end
         MD_ST_CALC: begin
            acc_d = is_div_q ? div_step : mul_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               state_d = MD_ST_FIX;
            end
         end
         MD_ST_FIX: begin
            if (is_div_q) begin
               // Divide by zero leaves |x| as remainder, so the sign fix-up restores raw x in HI
               hi_d = x_neg_q ? neg_out[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
               lo_d = (opnd_q == '0) ? '1 : (res_neg_q ? quot_neg : acc_q[WIDTH-1:0]);
            end else begin
               {hi_d, lo_d} = res_neg_q ? neg_out : acc_q;
            end
            done_d  = 1'b1;
            state_d = MD_ST_IDLE;
         end
         default: state_d = MD_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= MD_ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         is_div_q  <= 1'b0;
         res_neg_q <= 1'b0;
         x_neg_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         is_div_q  <= is_div_d;
         res_neg_q <= res_neg_d;
         x_neg_q   <= x_neg_d;
         done_q    <= done_d;
      end
   end

   // The done cycle is already IDLE (a new start is accepted there) but still reports busy
   assign md.busy = (state_q != MD_ST_IDLE) || done_q;
   assign md.done = done_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Bench for seq_mul_div: arithmetic reference model with per-cycle comparison plus directed literals.
module tb_seq_mul_div;
   import seq_mul_div_pkg::*;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   seq_mul_div_if #(.WIDTH(32)) md ();

   seq_mul_div #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .md  (md)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result {hi, lo} of a mul/div op
   function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
      logic [63:0] r;
      logic [31:0] q, rm;
      r = '0;
      case (op)
         MD_OP_MULTU: r = {32'b0, x} * {32'b0, y};
         MD_OP_MULT:  r = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
         MD_OP_DIVU:  r = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
         MD_OP_DIV: begin
            if (y == 0) r = {x, 32'hFFFFFFFF};
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
            else begin
               q  = $signed(x) / $signed(y);
               rm = $signed(x) % $signed(y);
               r  = {rm, q};
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Timeline model: k counts edges since an accepted start (1 after E0, 34 = done cycle)
   int          k;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;

   initial begin : model
      bit can;
      k = 0; m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            k = 0; m_hi = '0; m_lo = '0;
         end else begin
            can = (k == 0) || (k == 34);
            if (k > 0) k = k + 1;
            if (k == 34) begin
               m_hi = p_hi;
               m_lo = p_lo;
            end
            if (k == 35) k = 0;
            if (can && md.start) begin
               if (md.op inside {MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU}) begin
                  {p_hi, p_lo} = md_ref(md.op, md.data_x, md.data_y);
                  k = 1;
               end else if (md.op == MD_OP_MTHI) m_hi = md.data_x;
               else if (md.op == MD_OP_MTLO) m_lo = md.data_x;
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("cyc_busy", {31'b0, md.busy}, {31'b0, k > 0});
            chk("cyc_done", {31'b0, md.done}, {31'b0, k == 34});
            chk("cyc_hi", md.hi, m_hi);
            chk("cyc_lo", md.lo, m_lo);
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      md.op = op; md.data_x = x; md.data_y = y; md.start = 1'b1;
      @(negedge clk);
      md.start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (md.busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_idle_timeout"}, {31'b0, md.busy}, 32'd0);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input string name);
      int busy_n, done_at, n;
      issue(op, x, y);
      busy_n = 0; done_at = -1; n = 0;
      while (md.busy && n < 60) begin
         if (md.done) done_at = busy_n;
         busy_n++; n++;
         @(negedge clk);
      end
      chk({name, "_busy_cycles"}, busy_n, 32'd34);
      chk({name, "_done_slot"}, done_at, 32'd33);
      chk({name, "_hi"}, md.hi, eh);
      chk({name, "_lo"}, md.lo, el);
   endtask

   initial begin : stim
      int n, dones;
      rst = 1'b1; md.start = 1'b0; md.op = '0; md.data_x = '0; md.data_y = '0;
      #3;
      chk("rst_busy", {31'b0, md.busy}, 32'd0);
      chk("rst_done", {31'b0, md.done}, 32'd0);
      chk("rst_hi", md.hi, 32'd0);
      chk("rst_lo", md.lo, 32'd0);
      @(negedge clk); #2 rst = 1'b0;

      run_op(MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
      run_op(MD_OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7");
      run_op(MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2");
      run_op(MD_OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2");
      run_op(MD_OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, "divu_by0");
      run_op(MD_OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0");
      run_op(MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_wrap");

      // MTHI then MTLO on consecutive cycles
      @(negedge clk);
      md.op = MD_OP_MTHI; md.data_x = 32'h12345678; md.start = 1'b1;
      @(negedge clk);
      chk("mthi_hi", md.hi, 32'h12345678);
      chk("mthi_busy", {31'b0, md.busy}, 32'd0);
      md.op = MD_OP_MTLO; md.data_x = 32'h9ABCDEF0;
      @(negedge clk);
      md.start = 1'b0;
      chk("mtlo_lo", md.lo, 32'h9ABCDEF0);
      chk("mtlo_hi", md.hi, 32'h12345678);
      chk("mtlo_done", {31'b0, md.done}, 32'd0);

      // Start pulsed mid-CALC must be ignored
      issue(MD_OP_DIVU, 32'd10, 32'd3);
      repeat (10) @(negedge clk);
      md.op = MD_OP_MULTU; md.data_x = 32'd2; md.data_y = 32'd3; md.start = 1'b1;
      @(negedge clk);
      md.start = 1'b0;
      dones = 0; n = 0;
      while (n < 80) begin
         if (md.done) dones++;
         @(negedge clk);
         n++;
      end
      chk("ignore_dones", dones, 32'd1);
      chk("ignore_hi", md.hi, 32'd1);
      chk("ignore_lo", md.lo, 32'd3);

      // Back-to-back: new start accepted during the done cycle
      issue(MD_OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFC);
      n = 0;
      while (!md.done && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_done_seen", {31'b0, md.done}, 32'd1);
      chk("b2b_first_hi", md.hi, 32'd0);
      chk("b2b_first_lo", md.lo, 32'd20);
      md.op = MD_OP_DIVU; md.data_x = 32'd100; md.data_y = 32'd7; md.start = 1'b1;
      @(negedge clk);
      md.start = 1'b0;
      chk("b2b_second_busy", {31'b0, md.busy}, 32'd1);
      chk("b2b_second_done", {31'b0, md.done}, 32'd0);
      wait_idle("b2b");
      chk("b2b_second_hi", md.hi, 32'd2);
      chk("b2b_second_lo", md.lo, 32'd14);

      // Reset mid-iteration discards the operation and clears HI/LO
      issue(MD_OP_MULT, 32'd5, 32'd6);
      repeat (14) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", {31'b0, md.busy}, 32'd0);
      chk("midrst_done", {31'b0, md.done}, 32'd0);
      chk("midrst_hi", md.hi, 32'd0);
      chk("midrst_lo", md.lo, 32'd0);
      @(negedge clk); #2 rst = 1'b0;
      run_op(MD_OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "after_rst");

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
